// File: rtl/write_back_unit.sv
// Write-back stage: W pipeline register, load extraction, result mux and retire counter.
// A load whose data is late stalls the pipeline until ReadValidW or MEM_TIMEOUT; a timeout drops the write and sets MemErrW.
module write_back_unit #(
    parameter int XLEN        = 32,
    parameter int CNTW        = 64,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallW,
    input  logic            FlushW,
    input  logic            ValidM,
    input  logic            RegWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic [2:0]      LoadTypeM,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] PCPlus4M,
    input  logic [XLEN-1:0] ImmExtM,
    input  logic [4:0]      RdM,
    input  logic [XLEN-1:0] ReadDataW,
    input  logic            ReadValidW,
    output logic            RegWriteW,
    output logic [4:0]      RdW,
    output logic [XLEN-1:0] ResultW,
    output logic            WbStallReq,
    output logic            MemErrW,
    output logic [CNTW-1:0] InstRetW
);

    localparam int WCW = $clog2(MEM_TIMEOUT);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MEM_TIMEOUT - 1);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic            valid_q;
    logic            regwrite_q;
    logic [1:0]      src_q;
    logic [2:0]      ltype_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] pc4_q;
    logic [XLEN-1:0] imm_q;
    logic [4:0]      rd_q;

    logic [0:0]      state_q, state_d;
    logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
    logic            mem_err_q, mem_err_d;
    logic [CNTW-1:0] inst_ret_q, inst_ret_d;

    logic            load_pending;
    logic            timeout_cyc;
    logic            retire;
    logic            hold_w;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_data;

    assign load_pending = valid_q & (src_q == 2'b01) & ~ReadValidW;
    assign timeout_cyc  = load_pending & (state_q == ST_WAIT) & (wait_cnt_q == WAIT_MAX);
    assign WbStallReq   = load_pending & ~timeout_cyc;
    assign retire       = valid_q & ~WbStallReq & ~StallW;
    assign hold_w       = StallW | WbStallReq;

    always_comb begin
        byte_sel = ReadDataW[7:0];
        case (alu_q[1:0])
            2'd1:    byte_sel = ReadDataW[15:8];
            2'd2:    byte_sel = ReadDataW[23:16];
            2'd3:    byte_sel = ReadDataW[31:24];
            default: byte_sel = ReadDataW[7:0];
        endcase
        half_sel = alu_q[1] ? ReadDataW[31:16] : ReadDataW[15:0];
        case (ltype_q)
            3'b000:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data = ReadDataW;
        endcase
    end

    always_comb begin
        case (src_q)
            2'b01:   ResultW = load_data;
            2'b10:   ResultW = pc4_q;
            2'b11:   ResultW = imm_q;
            default: ResultW = alu_q;
        endcase
    end

    assign RegWriteW = valid_q & regwrite_q & (rd_q != 5'd0) & ~load_pending;
    assign RdW       = rd_q;
    assign MemErrW   = mem_err_q;
    assign InstRetW  = inst_ret_q;

    // Leaving WAIT on !load_pending also covers a flushed load, so a bubble never times out.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (load_pending) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WCW'(1);
                end
            end
            default: begin
                if (!load_pending || wait_cnt_q == WAIT_MAX) begin
                    state_d = ST_RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
        endcase
        mem_err_d  = mem_err_q | timeout_cyc;
        inst_ret_d = retire ? inst_ret_q + CNTW'(1) : inst_ret_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            src_q      <= 2'b00;
            ltype_q    <= 3'b000;
            alu_q      <= '0;
            pc4_q      <= '0;
            imm_q      <= '0;
            rd_q       <= 5'd0;
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
            inst_ret_q <= '0;
        end else begin
            if (FlushW) begin
                valid_q    <= 1'b0;
                regwrite_q <= 1'b0;
            end else if (!hold_w) begin
                valid_q    <= ValidM;
                regwrite_q <= RegWriteM;
                src_q      <= ResultSrcM;
                ltype_q    <= LoadTypeM;
                alu_q      <= ALUResultM;
                pc4_q      <= PCPlus4M;
                imm_q      <= ImmExtM;
                rd_q       <= RdM;
            end
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
            inst_ret_q <= inst_ret_d;
        end
    end

endmodule

// File: tb/tb_write_back_unit.sv
// Scoreboard bench for write_back_unit: expected register writes are queued at issue and popped by a monitor.
module tb_write_back_unit;

    localparam int XLEN        = 32;
    localparam int CNTW        = 8;
    localparam int MEM_TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            StallW, FlushW, ValidM, RegWriteM;
    logic [1:0]      ResultSrcM;
    logic [2:0]      LoadTypeM;
    logic [XLEN-1:0] ALUResultM, PCPlus4M, ImmExtM;
    logic [4:0]      RdM;
    logic [XLEN-1:0] ReadDataW;
    logic            ReadValidW;
    logic            RegWriteW;
    logic [4:0]      RdW;
    logic [XLEN-1:0] ResultW;
    logic            WbStallReq;
    logic            MemErrW;
    logic [CNTW-1:0] InstRetW;

    write_back_unit #(.XLEN(XLEN), .CNTW(CNTW), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .LoadTypeM(LoadTypeM),
        .ALUResultM(ALUResultM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM), .RdM(RdM),
        .ReadDataW(ReadDataW), .ReadValidW(ReadValidW),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .WbStallReq(WbStallReq), .MemErrW(MemErrW), .InstRetW(InstRetW)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t       exp_q[$];
    wr_t       mon_e;
    int        vectors     = 0;
    int        miscompares = 0;
    logic [7:0] exp_ret;
    int        n_stall;
    int        k;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data);
        wr_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic drive_m(input logic v, input logic rw, input logic [1:0] src,
                           input logic [2:0] lt, input logic [31:0] alu, input logic [4:0] rd);
        ValidM     = v;
        RegWriteM  = rw;
        ResultSrcM = src;
        LoadTypeM  = lt;
        ALUResultM = alu;
        PCPlus4M   = alu + 32'd4;
        ImmExtM    = alu ^ 32'hFFFF_0000;
        RdM        = rd;
    endtask

    task automatic idle_m();
        drive_m(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every register-file write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (RegWriteW === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%08h, required no write", RdW, ResultW);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_rd", 64'(RdW), 64'(mon_e.rd));
                chk("wb_data", 64'(ResultW), 64'(mon_e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; StallW = 1'b0; FlushW = 1'b0;
        ReadDataW = 32'h0; ReadValidW = 1'b0;
        idle_m();
        exp_ret = 8'd0;
        tick(); tick();
        chk("rst_regwrite", 64'(RegWriteW), 64'd0);
        chk("rst_rd", 64'(RdW), 64'd0);
        chk("rst_result", 64'(ResultW), 64'd0);
        chk("rst_stall", 64'(WbStallReq), 64'd0);
        chk("rst_memerr", 64'(MemErrW), 64'd0);
        chk("rst_instret", 64'(InstRetW), 64'd0);
        reset = 1'b0;

        // ALU, PC+4 and ImmExt results
        drive_m(1'b1, 1'b1, 2'b00, 3'b010, 32'h1234, 5'd5); push(5'd5, 32'h0000_1234);
        tick();
        chk("alu_regwrite", 64'(RegWriteW), 64'd1);
        chk("alu_rd", 64'(RdW), 64'd5);
        chk("alu_result", 64'(ResultW), 64'h1234);
        chk("alu_cnt_before", 64'(InstRetW), 64'd0);
        drive_m(1'b1, 1'b1, 2'b10, 3'b000, 32'h200, 5'd6); push(5'd6, 32'h0000_0204);
        tick(); exp_ret++;
        chk("alu_cnt_after", 64'(InstRetW), 64'd1);
        chk("pc4_result", 64'(ResultW), 64'h204);
        drive_m(1'b1, 1'b1, 2'b11, 3'b000, 32'h300, 5'd7); push(5'd7, 32'hFFFF_0300);
        tick(); exp_ret++;
        idle_m();
        chk("imm_result", 64'(ResultW), 64'hFFFF_0300);
        tick(); exp_ret++;
        chk("cnt_after_basic", 64'(InstRetW), 64'(exp_ret));

        // Back-to-back loads with data already valid
        ReadDataW = 32'h80FF_7F01;
        drive_m(1'b1, 1'b1, 2'b01, 3'b000, 32'h3, 5'd8); push(5'd8, 32'hFFFF_FF80);
        tick();
        ReadValidW = 1'b1;
        drive_m(1'b1, 1'b1, 2'b01, 3'b100, 32'h3, 5'd9); push(5'd9, 32'h0000_0080);
        #1;
        chk("lb_result", 64'(ResultW), 64'hFFFF_FF80);
        chk("lb_nostall", 64'(WbStallReq), 64'd0);
        tick(); exp_ret++;
        drive_m(1'b1, 1'b1, 2'b01, 3'b001, 32'h2, 5'd10); push(5'd10, 32'hFFFF_80FF);
        #1 chk("lbu_result", 64'(ResultW), 64'h80);
        tick(); exp_ret++;
        drive_m(1'b1, 1'b1, 2'b01, 3'b101, 32'h0, 5'd11); push(5'd11, 32'h0000_7F01);
        #1 chk("lh_result", 64'(ResultW), 64'hFFFF_80FF);
        tick(); exp_ret++;
        drive_m(1'b1, 1'b1, 2'b01, 3'b010, 32'h5, 5'd12); push(5'd12, 32'h80FF_7F01);
        #1 chk("lhu_result", 64'(ResultW), 64'h7F01);
        tick(); exp_ret++;
        idle_m();
        #1 chk("lw_result", 64'(ResultW), 64'h80FF_7F01);
        tick(); exp_ret++;
        ReadValidW = 1'b0;
        chk("cnt_after_loads", 64'(InstRetW), 64'd8);

        // Load waits three cycles for data; a younger ALU op waits behind it
        ReadDataW = 32'hDEAD_BEEF;
        drive_m(1'b1, 1'b1, 2'b01, 3'b010, 32'h100, 5'd13); push(5'd13, 32'hDEAD_BEEF);
        tick();
        drive_m(1'b1, 1'b1, 2'b00, 3'b000, 32'h55, 5'd14); push(5'd14, 32'h0000_0055);
        for (int c = 0; c < 3; c++) begin
            chk("ldwait_stall", 64'(WbStallReq), 64'd1);
            chk("ldwait_nowrite", 64'(RegWriteW), 64'd0);
            chk("ldwait_cnt", 64'(InstRetW), 64'(exp_ret));
            tick();
        end
        ReadValidW = 1'b1;
        #1;
        chk("ldwait_release", 64'(WbStallReq), 64'd0);
        chk("ldwait_write", 64'(RegWriteW), 64'd1);
        chk("ldwait_result", 64'(ResultW), 64'hDEAD_BEEF);
        tick(); exp_ret++;
        ReadValidW = 1'b0;
        chk("ldwait_cnt_once", 64'(InstRetW), 64'(exp_ret));
        chk("after_wait_rd", 64'(RdW), 64'd14);
        idle_m();
        tick(); exp_ret++;

        // rd=x0 never writes; flush alongside a retire
        drive_m(1'b1, 1'b1, 2'b00, 3'b000, 32'h99, 5'd0);
        tick();
        chk("x0_nowrite", 64'(RegWriteW), 64'd0);
        drive_m(1'b1, 1'b1, 2'b00, 3'b000, 32'h77, 5'd15);
        FlushW = 1'b1;
        tick(); exp_ret++;
        FlushW = 1'b0;
        idle_m();
        chk("flush_nowrite", 64'(RegWriteW), 64'd0);
        chk("flush_cnt_retire", 64'(InstRetW), 64'(exp_ret));
        tick();
        chk("bubble_nocount", 64'(InstRetW), 64'(exp_ret));

        // External stall repeats the write but counts once
        drive_m(1'b1, 1'b1, 2'b00, 3'b000, 32'hABCD, 5'd16);
        push(5'd16, 32'h0000_ABCD); push(5'd16, 32'h0000_ABCD); push(5'd16, 32'h0000_ABCD);
        tick();
        StallW = 1'b1;
        idle_m();
        chk("stallw_write", 64'(RegWriteW), 64'd1);
        tick();
        chk("stallw_rd", 64'(RdW), 64'd16);
        chk("stallw_cnt_held", 64'(InstRetW), 64'(exp_ret));
        tick();
        StallW = 1'b0;
        chk("stallw_result", 64'(ResultW), 64'hABCD);
        tick(); exp_ret++;
        chk("stallw_cnt_once", 64'(InstRetW), 64'(exp_ret));

        // Load that never gets data times out
        drive_m(1'b1, 1'b1, 2'b01, 3'b010, 32'h40, 5'd17);
        tick();
        drive_m(1'b1, 1'b1, 2'b00, 3'b000, 32'h1616, 5'd18); push(5'd18, 32'h0000_1616);
        n_stall = 0;
        for (int i = 0; i < 40 && WbStallReq; i++) begin
            n_stall++;
            tick();
        end
        chk("timeout_stall_cycles", 64'(n_stall), 64'd15);
        chk("timeout_nowrite", 64'(RegWriteW), 64'd0);
        chk("timeout_memerr_before", 64'(MemErrW), 64'd0);
        tick(); exp_ret++;
        idle_m();
        chk("timeout_memerr_set", 64'(MemErrW), 64'd1);
        chk("timeout_cnt", 64'(InstRetW), 64'(exp_ret));
        tick(); exp_ret++;
        chk("memerr_sticky", 64'(MemErrW), 64'd1);
        chk("cnt_after_timeout", 64'(InstRetW), 64'(exp_ret));

        // Counter wrap with CNTW=8
        k = 255 - int'(exp_ret);
        drive_m(1'b1, 1'b0, 2'b00, 3'b000, 32'h0, 5'd0);
        repeat (k) tick();
        idle_m();
        tick();
        chk("cnt_allones", 64'(InstRetW), 64'hFF);
        drive_m(1'b1, 1'b0, 2'b00, 3'b000, 32'h0, 5'd1);
        tick();
        idle_m();
        tick();
        chk("cnt_wrap", 64'(InstRetW), 64'd0);

        // Reset while waiting on a load
        drive_m(1'b1, 1'b1, 2'b01, 3'b010, 32'h80, 5'd19);
        tick();
        idle_m();
        tick();
        chk("rstwait_stall", 64'(WbStallReq), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstwait_regwrite", 64'(RegWriteW), 64'd0);
        chk("rstwait_rd", 64'(RdW), 64'd0);
        chk("rstwait_result", 64'(ResultW), 64'd0);
        chk("rstwait_stall_clr", 64'(WbStallReq), 64'd0);
        chk("rstwait_memerr", 64'(MemErrW), 64'd0);
        chk("rstwait_instret", 64'(InstRetW), 64'd0);
        drive_m(1'b1, 1'b1, 2'b00, 3'b000, 32'h2222, 5'd20); push(5'd20, 32'h0000_2222);
        tick();
        idle_m();
        chk("post_rst_write", 64'(RegWriteW), 64'd1);
        chk("post_rst_nostall", 64'(WbStallReq), 64'd0);
        tick();
        chk("post_rst_cnt", 64'(InstRetW), 64'd1);

        tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
